// File: rtl/idct_row_stream.sv
// idct_row_stream: streaming row pass of the HEVC-style integer inverse DCT
// for 4-point and 8-point transforms.
//
// Each coefficient is multiplied into all eight accumulators as it arrives,
// so no input delay line is needed. A completed block is rounded, shifted and
// saturated into a one-block output buffer. The buffer drains while the next
// block accumulates, which lets the pass absorb backpressure.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous abort of the partial block and the output buffer
//   mode[1:0]          00 = 4-pt, 01 = 8-pt, 1x = reserved (run as 8-pt);
//                      sampled on the first beat of each block
//   in_valid/in_ready  input handshake; in_data is the signed coefficient X_n
//   out_valid/out_ready output handshake; out_data is the signed sample y_k
//   out_idx            k of the current out_data
//   out_last           high with the last sample of a block
//   mode_err           one-cycle pulse when a block starts with reserved mode
module idct_row_stream #(
  parameter int DW    = 16,
  parameter int SHIFT = 7,
  parameter int ACCW  = DW + 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          mode_err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [ACCW-1:0] RND  = ACCW'(1 << (SHIFT - 1));
  localparam logic signed [ACCW-1:0] MAXV = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(-(1 << (DW - 1)));

  // HEVC 8-pt basis C8[row][k]. Only k = 0..3 is tabulated: even rows are
  // mirror-symmetric about the centre and odd rows are antisymmetric.
  function automatic logic signed [7:0] coef(input logic [2:0] row, input logic [2:0] k);
    logic [1:0]        kk;
    logic signed [7:0] c;
    int                t [4];
    kk = k[2] ? ~k[1:0] : k[1:0];
    case (row)
      3'd0:    t = '{64, 64, 64, 64};
      3'd1:    t = '{89, 75, 50, 18};
      3'd2:    t = '{83, 36, -36, -83};
      3'd3:    t = '{75, -18, -89, -50};
      3'd4:    t = '{64, -64, -64, 64};
      3'd5:    t = '{50, -89, 18, 75};
      3'd6:    t = '{36, -83, 83, -36};
      default: t = '{18, -50, 75, -89};
    endcase
    c = 8'(t[kk]);
    if (k[2] && row[0]) c = -c;
    return c;
  endfunction

  // Arithmetic shift makes negative halves round toward +inf.
  function automatic logic signed [DW-1:0] rnd_sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = (a + RND) >>> SHIFT;
    if (s > MAXV)      s = MAXV;
    else if (s < MINV) s = MINV;
    return s[DW-1:0];
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_n;
  logic                   r_mode4;
  logic                   r_merr;
  logic                   r_oval;
  logic [2:0]             r_idx;
  logic                   r_bn4;
  logic signed [ACCW-1:0] r_acc [8];
  logic signed [DW-1:0]   r_buf [8];

  logic signed [DW-1:0]   w_x;
  logic signed [ACCW-1:0] w_prod [8];
  logic                   w_four;
  logic [2:0]             w_row;
  logic                   w_blk_end;
  logic                   w_accept;
  logic                   w_buf_free;
  logic                   w_load;

  assign w_x       = in_data;
  // Mode is live on beat 0 and latched for the rest of the block.
  assign w_four    = (r_n == 3'd0) ? (mode == 2'b00) : r_mode4;
  // 4-pt row n uses the even 8-pt row 2n.
  assign w_row     = w_four ? {r_n[1:0], 1'b0} : r_n;
  assign w_blk_end = w_four ? (r_n == 3'd3) : (r_n == 3'd7);
  assign w_accept  = !flush && in_valid && in_ready;

  assign out_valid  = r_oval;
  assign out_idx    = r_idx;
  assign out_last   = r_oval && (r_idx == (r_bn4 ? 3'd3 : 3'd7));
  assign out_data   = r_oval ? r_buf[r_idx] : '0;
  assign mode_err   = r_merr;
  assign w_buf_free = !r_oval || (out_ready && out_last);

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_prod[k] = ACCW'(coef(w_row, 3'(k))) * ACCW'(w_x);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && w_blk_end) w_state_nxt = HOLD;
        HOLD:    if (w_buf_free)            w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready = (r_state == ACCUM);
    w_load   = (r_state == HOLD) && w_buf_free && !flush;
  end

  // Stage: multiply-accumulate on each accepted beat; beat 0 restarts the sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_acc[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < 8; k++) r_acc[k] <= ((r_n == 3'd0) ? '0 : r_acc[k]) + w_prod[k];
    end
  end

  // Stage: round/shift/saturate into the output buffer.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < 8; k++) r_buf[k] <= rnd_sat(r_acc[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= '0;
      r_mode4 <= 1'b0;
      r_merr  <= 1'b0;
      r_oval  <= 1'b0;
      r_idx   <= '0;
      r_bn4   <= 1'b0;
    end else if (flush) begin
      r_n    <= '0;
      r_merr <= 1'b0;
      r_oval <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_merr <= w_accept && (r_n == 3'd0) && mode[1];
      if (w_accept) begin
        if (r_n == 3'd0) r_mode4 <= (mode == 2'b00);
        // The counter parks on N-1 during HOLD and clears when the block unloads.
        if (!w_blk_end)  r_n <= r_n + 3'd1;
      end
      if (w_load) begin
        r_n    <= '0;
        r_oval <= 1'b1;
        r_idx  <= '0;
        r_bn4  <= r_mode4;
      end else if (r_oval && out_ready) begin
        if (out_last) begin
          r_oval <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx  <= r_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_row_stream.sv
module tb_idct_row_stream;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_last, mode_err;
  logic [1:0]  mode;
  logic [15:0] in_data, out_data;
  logic [2:0]  out_idx;

  int checks = 0;
  int failures = 0;

  // Captured output beats and mode_err high cycles (written only by the monitor).
  int gd [$];
  int gi [$];
  bit gl [$];
  int merr_cyc = 0;

  // HEVC 8-pt basis, C8[n][k].
  int C8 [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}};

  idct_row_stream #(.DW(16), .SHIFT(7), .ACCW(26)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .mode_err(mode_err));

  always #5 clk = ~clk;

  // Inputs only change #1 after a rising edge, so the falling-edge view of a
  // handshake is exactly what the next rising edge will take.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      gd.push_back(int'($signed(out_data)));
      gi.push_back(int'(out_idx));
      gl.push_back(out_last);
    end
    if (mode_err) merr_cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // y_k = sat(floor((sum_n C[n][k]*X_n + 64) / 128)), C4[n][k] = C8[2n][k].
  function automatic int ref_y(input bit four, input int x[8], input int k);
    longint s = 0;
    int     npts = four ? 4 : 8;
    for (int n = 0; n < npts; n++) s += longint'(C8[four ? 2 * n : n][k]) * longint'(x[n]);
    s = (s + 64) >>> 7;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic put_beat(input logic [1:0] m, input int x);
    int w = 0;
    mode = m; in_data = 16'(x); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 500) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL put_beat in_ready stuck got=0 want=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int w = 0;
    while (gd.size() < target && w < 3000) begin @(negedge clk); w++; end
    if (gd.size() < target) begin
      checks++; failures++;
      $display("FAIL wait_out timeout beats got=%0d want=%0d", gd.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_idx !== 3'd0 || out_last !== 1'b0 ||
        mode_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%0b d=%0h i=%0d l=%0b e=%0b r=%0b want 0 0 0 0 0 1",
               out_valid, out_data, out_idx, out_last, mode_err, in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_reset got r=%0b v=%0b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_impulse8();
    int x[8] = '{128, 0, 0, 0, 0, 0, 0, 0};
    int base;
    @(posedge clk); #1; out_ready = 1'b1; base = gd.size();
    for (int i = 0; i < 8; i++) put_beat(2'b01, x[i]);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL t1_hold got v=%0b r=%0b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || $signed(out_data) !== 64) begin
      failures++;
      $display("FAIL t1_first got v=%0b i=%0d d=%0d want 1 0 64", out_valid, out_idx, $signed(out_data));
    end
    wait_out(base + 8);
    for (int i = 0; i < 8; i++) begin
      if (gd.size() > base + i) begin
        checks++;
        if (gd[base+i] !== 64 || gi[base+i] !== i || gl[base+i] !== (i == 7)) begin
          failures++;
          $display("FAIL t1_y%0d got d=%0d i=%0d l=%0b want 64 %0d %0b", i, gd[base+i], gi[base+i], gl[base+i], i, i == 7);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (gd.size() != base + 8 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_count got beats=%0d v=%0b want 8 0", gd.size() - base, out_valid);
    end
  endtask

  task automatic test_4pt(input string tag);
    int x[4] = '{0, 128, 0, 0};
    int e[4] = '{83, 36, -36, -83};
    int base, m0;
    @(posedge clk); #1; out_ready = 1'b1; base = gd.size(); m0 = merr_cyc;
    for (int i = 0; i < 4; i++) put_beat(2'b00, x[i]);
    wait_out(base + 4);
    for (int i = 0; i < 4; i++) begin
      if (gd.size() > base + i) begin
        checks++;
        if (gd[base+i] !== e[i] || gi[base+i] !== i || gl[base+i] !== (i == 3)) begin
          failures++;
          $display("FAIL %s_y%0d got d=%0d i=%0d l=%0b want %0d %0d %0b", tag, i, gd[base+i], gi[base+i], gl[base+i], e[i], i, i == 3);
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (gd.size() != base + 4 || merr_cyc != m0) begin
      failures++;
      $display("FAIL %s_count got beats=%0d merr=%0d want 4 0", tag, gd.size() - base, merr_cyc - m0);
    end
  endtask

  task automatic test_saturation();
    int x[8];
    int base;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) x[i] = (pass == 0) ? 32767 : -32768;
      @(posedge clk); #1; out_ready = 1'b1; base = gd.size();
      for (int i = 0; i < 8; i++) put_beat(2'b01, x[i]);
      wait_out(base + 8);
      if (gd.size() > base) begin
        checks++;
        if (gd[base] !== ((pass == 0) ? 32767 : -32768)) begin
          failures++;
          $display("FAIL sat_y0_pass%0d got=%0d want=%0d", pass, gd[base], (pass == 0) ? 32767 : -32768);
        end
      end
      for (int k = 1; k < 8; k++) begin
        if (gd.size() > base + k) begin
          checks++;
          if (gd[base+k] !== ref_y(1'b0, x, k)) begin
            failures++;
            $display("FAIL sat_y%0d_pass%0d got=%0d want=%0d", k, pass, gd[base+k], ref_y(1'b0, x, k));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int x1[8], x2[8];
    int e[16];
    int base;
    for (int i = 0; i < 8; i++) begin
      x1[i] = int'($signed(16'($urandom)));
      x2[i] = int'($signed(16'($urandom)));
    end
    for (int k = 0; k < 8; k++) begin e[k] = ref_y(1'b0, x1, k); e[8+k] = ref_y(1'b0, x2, k); end
    @(posedge clk); #1; out_ready = 1'b0; base = gd.size();
    for (int i = 0; i < 8; i++) put_beat(2'b01, x1[i]);
    for (int i = 0; i < 8; i++) put_beat(2'b01, x2[i]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 3'd0 || $signed(out_data) !== e[0]) begin
        failures++;
        $display("FAIL b2b_stall%0d got r=%0b v=%0b i=%0d d=%0d want 0 1 0 %0d", c, in_ready, out_valid, out_idx, $signed(out_data), e[0]);
      end
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_out(base + 16);
    for (int i = 0; i < 16; i++) begin
      if (gd.size() > base + i) begin
        checks++;
        if (gd[base+i] !== e[i] || gi[base+i] !== i % 8 || gl[base+i] !== (i % 8 == 7)) begin
          failures++;
          $display("FAIL b2b_y%0d got d=%0d i=%0d l=%0b want %0d %0d %0b", i, gd[base+i], gi[base+i], gl[base+i], e[i], i % 8, i % 8 == 7);
        end
      end
    end
  endtask

  task automatic test_mode_latch();
    int x[8];
    int base, m0;
    logic [1:0] m;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) x[i] = $urandom_range(0, 4000) - 2000;
      @(posedge clk); #1; out_ready = 1'b1; base = gd.size(); m0 = merr_cyc;
      for (int i = 0; i < 8; i++) begin
        if (i == 0) m = (pass == 0) ? 2'b01 : 2'b10;
        else        m = (i < 4) ? 2'b01 : 2'b00;
        put_beat(m, x[i]);
        if (i == 0) begin
          checks++;
          if (mode_err !== (pass == 1)) begin
            failures++;
            $display("FAIL mode_err_beat0_pass%0d got=%0b want=%0b", pass, mode_err, pass == 1);
          end
        end
      end
      wait_out(base + 8);
      for (int k = 0; k < 8; k++) begin
        if (gd.size() > base + k) begin
          checks++;
          if (gd[base+k] !== ref_y(1'b0, x, k) || gi[base+k] !== k || gl[base+k] !== (k == 7)) begin
            failures++;
            $display("FAIL mode_y%0d_pass%0d got d=%0d i=%0d l=%0b want %0d %0d %0b", k, pass, gd[base+k], gi[base+k], gl[base+k], ref_y(1'b0, x, k), k, k == 7);
          end
        end
      end
      checks++;
      if (merr_cyc - m0 != pass) begin
        failures++;
        $display("FAIL mode_err_width_pass%0d got=%0d want=%0d", pass, merr_cyc - m0, pass);
      end
    end
  endtask

  task automatic test_abort();
    int x[8];
    for (int i = 0; i < 8; i++) x[i] = $urandom_range(0, 2000) - 1000;
    // Reset with a held block in the buffer and a partial block accumulating.
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_beat(2'b01, x[i]);
    for (int i = 0; i < 5; i++) put_beat(2'b01, x[i]);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset got v=%0b r=%0b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    test_4pt("after_reset");
    // Flush during drain, with an input beat offered on the flush cycle.
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) put_beat(2'b01, x[i]);
    wait_out(gd.size() + 3);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd1000; mode = 2'b01;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_flush got v=%0b i=%0d l=%0b r=%0b want 0 0 0 1", out_valid, out_idx, out_last, in_ready);
    end
    test_4pt("after_flush");
  endtask

  bit rnd_done;

  task automatic test_random();
    int ed [$];
    int ei [$];
    int base, total;
    int x[8];
    bit four;
    logic [1:0] m0;
    @(posedge clk); #1; base = gd.size(); rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 12; b++) begin
          m0   = 2'($urandom_range(0, 1));
          four = (m0 == 2'b00);
          for (int i = 0; i < 8; i++) x[i] = int'($signed(16'($urandom)));
          for (int k = 0; k < (four ? 4 : 8); k++) begin ed.push_back(ref_y(four, x, k)); ei.push_back(k); end
          for (int i = 0; i < (four ? 4 : 8); i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            put_beat((i == 0) ? m0 : 2'($urandom), x[i]);
          end
        end
        total = ed.size();
        wait_out(base + total);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < total; i++) begin
      if (gd.size() > base + i) begin
        checks++;
        if (gd[base+i] !== ed[i] || gi[base+i] !== ei[i] ||
            gl[base+i] !== (i == total - 1 || ei[(i + 1) % total] == 0)) begin
          failures++;
          $display("FAIL rnd_beat%0d got d=%0d i=%0d l=%0b want d=%0d i=%0d", i, gd[base+i], gi[base+i], gl[base+i], ed[i], ei[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mode = 2'b01; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_impulse8();
    test_4pt("t2");
    test_saturation();
    test_back_to_back();
    test_mode_latch();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
